// File: rtl/dec_pkg.sv
// Shared ALU arithmetic definitions: default datapath width and the status flag bundle
// used by the arithmetic blocks.
package dec_pkg;

  localparam int ALU_WIDTH = 20;

  typedef struct packed {
    logic zero;
    logic neg;
    logic borrow;
  } alu_flags_t;

endpackage

// File: rtl/dec_core.sv
// Combinational decrement-by-one with borrow detection and optional clamp at zero.
module dec_core #(
  parameter int WIDTH    = dec_pkg::ALU_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  // Borrow out of the chain happens only for a zero operand
  always_comb begin
    borrow = (operand == {WIDTH{1'b0}});
    if (borrow && SATURATE) begin
      result = {WIDTH{1'b0}};
    end else begin
      result = operand - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dec.sv
// Registered decrementer: one-cycle latency, result and flags captured together,
// output holds when no qualified input arrives.
module dec
  import dec_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_input,
  output logic [WIDTH-1:0] decremented_output,
  output logic             out_valid,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             borrow_flag
);

  logic [WIDTH-1:0] next_result;
  logic             next_borrow;
  alu_flags_t       next_flags;

  logic [WIDTH-1:0] result_r;
  logic             valid_r;
  alu_flags_t       flags_r;

  dec_core #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_core (
    .operand(data_input),
    .result (next_result),
    .borrow (next_borrow)
  );

  // Flags derived from the same operand as the result so they never skew
  always_comb begin
    next_flags        = '0;
    next_flags.zero   = (next_result == {WIDTH{1'b0}});
    next_flags.neg    = next_result[WIDTH-1];
    next_flags.borrow = next_borrow;
  end

  // Output registers; reset wins over a coincident valid input
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      flags_r  <= '0;
    end else if (in_valid) begin
      result_r <= next_result;
      valid_r  <= 1'b1;
      flags_r  <= next_flags;
    end else begin
      valid_r  <= 1'b0;
    end
  end

  assign decremented_output = result_r;
  assign out_valid          = valid_r;
  assign zero_flag          = flags_r.zero;
  assign neg_flag           = flags_r.neg;
  assign borrow_flag        = flags_r.borrow;

endmodule

// File: tb/tb_dec.sv
// Directed and randomized checks of dec, with wrapping and saturating instances
// driven from the same stimulus.
module tb_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] data_input;

  logic [19:0] out0, out1;
  logic        ov0, ov1, z0, z1, n0, n1, b0, b1;

  int tests = 0;
  int fails = 0;

  logic [23:0] e0, e1;

  always #5 clk = ~clk;

  dec #(.WIDTH(20), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_input(data_input),
    .decremented_output(out0), .out_valid(ov0),
    .zero_flag(z0), .neg_flag(n0), .borrow_flag(b0)
  );

  dec #(.WIDTH(20), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_input(data_input),
    .decremented_output(out1), .out_valid(ov1),
    .zero_flag(z1), .neg_flag(n1), .borrow_flag(b1)
  );

  // Packed view: {result[19:0], valid, zero, neg, borrow}
  function automatic logic [23:0] pk(input logic [19:0] r, input logic v,
                                     input logic z, input logic n, input logic b);
    return {r, v, z, n, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    data_input = 20'h00000;
    tick;
    tick;
    chk("reset_wrap", pk(out0, ov0, z0, n0, b0), pk(20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("reset_sat",  pk(out1, ov1, z1, n1, b1), pk(20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    tick;
    chk("post_release", pk(out0, ov0, z0, n0, b0), pk(20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));

    in_valid = 1'b1; data_input = 20'h10000; tick;
    chk("op_10000_wrap", pk(out0, ov0, z0, n0, b0), pk(20'h0FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("op_10000_sat",  pk(out1, ov1, z1, n1, b1), pk(20'h0FFFF, 1'b1, 1'b0, 1'b0, 1'b0));

    data_input = 20'h00000; tick;
    chk("op_0_wrap", pk(out0, ov0, z0, n0, b0), pk(20'hFFFFF, 1'b1, 1'b0, 1'b1, 1'b1));
    chk("op_0_sat",  pk(out1, ov1, z1, n1, b1), pk(20'h00000, 1'b1, 1'b1, 1'b0, 1'b1));

    data_input = 20'h00001; tick;
    chk("op_1", pk(out0, ov0, z0, n0, b0), pk(20'h00000, 1'b1, 1'b1, 1'b0, 1'b0));

    data_input = 20'h80000; tick;
    chk("op_msb", pk(out0, ov0, z0, n0, b0), pk(20'h7FFFF, 1'b1, 1'b0, 1'b0, 1'b0));

    data_input = 20'hFFFFF; tick;
    chk("op_max", pk(out0, ov0, z0, n0, b0), pk(20'hFFFFE, 1'b1, 1'b0, 1'b1, 1'b0));

    // Back-to-back stream
    data_input = 20'h00005; tick;
    chk("stream_5", pk(out0, ov0, z0, n0, b0), pk(20'h00004, 1'b1, 1'b0, 1'b0, 1'b0));
    data_input = 20'h00004; tick;
    chk("stream_4", pk(out0, ov0, z0, n0, b0), pk(20'h00003, 1'b1, 1'b0, 1'b0, 1'b0));
    data_input = 20'h00003; tick;
    chk("stream_3", pk(out0, ov0, z0, n0, b0), pk(20'h00002, 1'b1, 1'b0, 1'b0, 1'b0));

    in_valid = 1'b0; data_input = 20'h00000; tick;
    chk("hold_1", pk(out0, ov0, z0, n0, b0), pk(20'h00002, 1'b0, 1'b0, 1'b0, 1'b0));
    data_input = 20'h12345; tick;
    chk("hold_2", pk(out0, ov0, z0, n0, b0), pk(20'h00002, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset coincident with a valid input discards it
    in_valid = 1'b1; data_input = 20'h00010; tick;
    chk("pre_rst", pk(out0, ov0, z0, n0, b0), pk(20'h0000F, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b1; data_input = 20'h00010; tick;
    chk("rst_vs_valid", pk(out0, ov0, z0, n0, b0), pk(20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0; in_valid = 1'b0;

    e0 = 24'h000000;
    e1 = 24'h000000;
    for (int i = 0; i < 10000; i++) begin
      logic [19:0] op;
      logic [19:0] r0, r1;
      logic        v;
      op = 20'($urandom);
      if ($urandom_range(0, 15) == 0) op = 20'h00000;
      if ($urandom_range(0, 15) == 1) op = 20'h00001;
      v = ($urandom_range(0, 3) != 0);
      in_valid   = v;
      data_input = op;
      if (v) begin
        r0 = (op == 20'h00000) ? 20'hFFFFF : op - 20'h00001;
        r1 = (op == 20'h00000) ? 20'h00000 : op - 20'h00001;
        e0 = pk(r0, 1'b1, (r0 == 20'h00000), r0[19], (op == 20'h00000));
        e1 = pk(r1, 1'b1, (r1 == 20'h00000), r1[19], (op == 20'h00000));
      end else begin
        e0[3] = 1'b0;
        e1[3] = 1'b0;
      end
      tick;
      chk("sweep_wrap", pk(out0, ov0, z0, n0, b0), e0);
      chk("sweep_sat",  pk(out1, ov1, z1, n1, b1), e1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dec.md
Name: dec

Overview:
- Registered 20-bit decrementer in the ALU arithmetic group. Computes data_input − 1 with status flags.
- One clock of latency; output and flags are captured on the rising edge of clk.
- Consumed by the ALU result mux and the flag logic; has no internal state beyond the output registers.

Parameters:
- WIDTH, 20, datapath width in bits for data_input and decremented_output.
- SATURATE, 0, 0 = modular wrap (0 → all-ones); 1 = clamp at 0 (0 → 0).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies data_input for the current cycle.
- data_input  input  WIDTH  operand to decrement.
- decremented_output  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle when decremented_output holds a result from a qualified input.
- zero_flag  output  1  registered; high when the result is 0.
- neg_flag  output  1  registered; equals the MSB of the result.
- borrow_flag  output  1  registered; high when the operand was 0, i.e. an underflow occurred.

Behaviour:
- Reset (rst=1 at the clock edge): decremented_output=0, out_valid=0, zero_flag=0, neg_flag=0, borrow_flag=0. Reset has priority over in_valid. A reset in the same cycle as a valid input discards that input.
- Latency is 1 cycle. When in_valid=1 at edge N, the result and flags are visible after edge N and out_valid=1 until edge N+1.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - decremented_output and the flags hold their last values.
- Back-to-back valid inputs are accepted every cycle (throughput 1/cycle). There is no backpressure.
- Arithmetic is unsigned, WIDTH bits, result = data_input − 1.
- Operand 0 with SATURATE=0: result = all-ones (0xFFFFF for WIDTH=20), borrow_flag=1, neg_flag=1, zero_flag=0.
- Operand 0 with SATURATE=1: result = 0, borrow_flag=1, zero_flag=1, neg_flag=0.
- Operand 1: result 0, zero_flag=1, borrow_flag=0.
- Operand at the MSB boundary (0x80000): result 0x7FFFF, neg_flag=0.
- Flags are computed from the same operand as the result and registered alongside it. Flags and result never skew by a cycle.
- Inputs are sampled only at the clock edge. data_input changing between edges has no effect on the outputs.
- The operation is a borrow-chain subtract of constant 1. Any synthesizable form (operator or explicit ripple) is acceptable, provided the result is identical for all 2^WIDTH inputs.

Decomposition:
- Shared ALU package holds:
  - constant ALU_WIDTH = 20, used as the default for WIDTH;
  - a packed flag struct {zero, neg, borrow} shared with the other ALU arithmetic blocks.
- One natural sub-module: dec_core, purely combinational. It takes the operand and SATURATE and produces the next result and the borrow.
- The top level adds the valid pipeline, the flag registers and the reset.

Test Plan:
- rst=1 for 2 cycles, then release → all outputs 0 and out_valid=0.
- in_valid=1, data_input=0x10000 → after one edge, decremented_output=0x0FFFF, out_valid=1, zero=0, neg=0, borrow=0.
- data_input=0x00000, SATURATE=0 → output 0xFFFFF, borrow=1, neg=1. Repeat with SATURATE=1 → output 0x00000, borrow=1, zero=1.
- data_input=0x00001 → output 0x00000, zero=1; then 0x80000 → output 0x7FFFF, neg=0; then 0xFFFFF → output 0xFFFFE, neg=1.
- Back-to-back stream 5, 4, 3 with in_valid held high → outputs 4, 3, 2 on consecutive cycles. Then in_valid=0 → out_valid drops and output holds 2.
- Assert rst in the same cycle as in_valid=1 with data_input=0x00010 → next cycle output=0 and out_valid=0. Afterwards a random sweep of 10k operands matches a reference model.
